div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divider in the Execute stage. Services DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle. It is the responder to the hazard unit's divider stall handshake. The hazard unit holds StallF, StallD and StallE while DivStart is high and DivDone is low. This block raises DivDone for exactly one cycle when the result is valid, which lets the Execute stage advance.

## Interface
- XLEN, 32: operand and result width; only 32 is supported.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- DivStart  input  1  Execute-stage instruction is a divide; held high and stable while stalled.
- DivOp  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcA  input  XLEN  dividend (forwarded SrcAE).
- SrcB  input  XLEN  divisor (forwarded SrcBE).
- DivResult  output  XLEN  quotient or remainder; valid while DivDone is high.
- DivDone  output  1  one-cycle completion pulse.
- DivBusy  output  1  operation in flight (CALC or DONE state).

## Operation
- States:
  - IDLE: no operation in flight.
  - CALC: 32 iteration cycles.
  - DONE: DivDone=1, DivResult registered and valid.
- IDLE with DivStart=1:
  - Latch DivOp, sign flags, |SrcA| and |SrcB|. Absolute values apply to signed ops only; DIVU/REMU latch the raw operands.
  - Clear the remainder register; set iteration count to 0.
  - Next state is CALC, except for the fast cases below.
- Fast cases, which go straight to DONE with no CALC cycles:
  - SrcB==0: quotient 0xFFFFFFFF; remainder = SrcA (unmodified).
  - Signed overflow, meaning a signed op with SrcA==0x80000000 and SrcB==0xFFFFFFFF: quotient 0x80000000; remainder 0.
- CALC, each cycle:
  - Compute {rem, quo} shifted left by 1.
  - Trial = rem − divisor, done 33 bits wide.
  - If the trial result is non-negative, take rem = trial and set quo[0]=1.
  - Increment the count. At count 31, next state is DONE.
- Entering DONE, sign fix-up:
  - Quotient is negated if the signed operand signs differ.
  - Remainder takes the sign of the dividend.
  - DivOp[1] selects remainder or quotient into DivResult.
- DONE always returns to IDLE next cycle. DivStart seen in the DONE cycle is ignored, because it belongs to the completing instruction.
- Abort: DivStart low while in CALC or DONE means next state is IDLE, and DivDone is not asserted afterward. This covers an Execute flush.
- Reset values: state IDLE, DivDone 0, DivBusy 0, DivResult 0, internal registers 0. Reset overrides everything, including mid-CALC.

## Timing
- Cycle 0: DivStart first seen in IDLE; DivDone=0.
- Normal path:
  - Cycles 1–32: CALC.
  - Cycle 33: DONE, DivDone=1.
  - Total latency is 33 cycles.
- Fast path: DONE in cycle 1, so latency is 1 cycle.
- DivDone is a registered output: DivDone = (state==DONE), with no combinational path from inputs.
- DivStart=1 but not yet in DONE means DivDone=0; this includes cycle 0, so the hazard unit stalls.
- Back-to-back divides: the cycle after DONE is IDLE. A new DivStart there is a new instruction and starts at its own cycle 0. Spacing is 34 cycles per normal divide.
- DivBusy is high in CALC and DONE, and low in IDLE.

## Structure
- Shared package div_pkg:
  - DivOp encodings: DIV_S, DIV_U, REM_S, REM_U.
  - State enum: IDLE, CALC, DONE.
  - XLEN constant.
- Sub-module div_step: the combinational single-iteration shift/subtract. It is instantiated once and is a reusable candidate for a future radix-4 variant.
- The FSM, operand registers, counter and sign fix-up stay in div_unit.

## Test plan
- DIV 100 / 7, DivStart held: DivDone only at cycle 33 with DivResult=14. REM same operands gives 2.
- Signed operands:
  - DIV −7 / 2 gives 0xFFFFFFFD (−3).
  - REM −7 / 2 gives 0xFFFFFFFF (−1).
  - DIVU 0xFFFFFFF9 / 2 gives 0x7FFFFFFC.
- Divide by zero:
  - DIVU 5/0 gives 0xFFFFFFFF with DivDone at cycle 1.
  - REM 5/0 gives 5 at cycle 1.
- Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 at cycle 1.
  - REM same operands gives 0 at cycle 1.
- Abort and reset:
  - Drop DivStart at cycle 10: DivBusy=0 at cycle 11, and DivDone never pulses.
  - Assert rst_n=0 at cycle 20 of another divide: all outputs 0 the next cycle.
  - A fresh DIV 9/3 afterwards gives 3 at its cycle 33.
- Back-to-back:
  - DIVU 1000/10, then DivStart kept high with new operands 81/9 in the cycle after DONE.
  - Results 100, then 9. DivDone pulses exactly twice, 34 cycles apart.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

    localparam int unsigned XLEN = 32;

    // funct3[1:0] encodings of the four divide/remainder ops
    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Two's-complement magnitude; only applied when the op is signed
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// Divider stall handshake between the Execute stage / hazard unit and div_unit.
interface div_if;
    import div_pkg::*;

    logic            DivStart;
    logic [1:0]      DivOp;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [XLEN-1:0] DivResult;
    logic            DivDone;
    logic            DivBusy;

    modport master (
        output DivStart, DivOp, SrcA, SrcB,
        input  DivResult, DivDone, DivBusy
    );

    modport slave (
        input  DivStart, DivOp, SrcA, SrcB,
        output DivResult, DivDone, DivBusy
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem < divisor holds on entry, so a 33-bit trial never wraps and its MSB is the sign
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        rem_o   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ~trial[XLEN]};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), responder to the hazard unit's divider stall.
module div_unit
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    div_if.slave bus
);
    state_e          state_q;
    logic            sel_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      cnt_q;
    logic            done_q;
    logic            busy_q;

    logic            signed_op;
    logic            is_div0;
    logic            is_ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fin_quo;
    logic [XLEN-1:0] fin_rem;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Operand decode for the start cycle and sign fix-up of the final iteration's result
    always_comb begin
        signed_op = (bus.DivOp == DIV_S) || (bus.DivOp == REM_S);
        is_div0   = (bus.SrcB == '0);
        is_ovf    = signed_op && (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);
        abs_a     = mag(bus.SrcA, signed_op);
        abs_b     = mag(bus.SrcB, signed_op);
        fin_quo   = neg_quo_q ? -step_quo : step_quo;
        fin_rem   = neg_rem_q ? -step_rem : step_rem;
    end

    // Control FSM with operand/iteration registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.DivStart) begin
                        sel_rem_q <= bus.DivOp[1];
                        neg_quo_q <= signed_op & (bus.SrcA[XLEN-1] ^ bus.SrcB[XLEN-1]);
                        neg_rem_q <= signed_op & bus.SrcA[XLEN-1];
                        divisor_q <= abs_b;
                        quo_q     <= abs_a;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (is_div0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.DivOp[1] ? bus.SrcA : '1;
                        end else if (is_ovf) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.DivOp[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!bus.DivStart) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= sel_rem_q ? fin_rem : fin_quo;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DivResult = result_q;
    assign bus.DivDone   = done_q;
    assign bus.DivBusy   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    div_if bus ();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.DivOp    = op;
        bus.SrcA     = a;
        bus.SrcB     = b;
        bus.DivStart = 1'b1;
    endtask

    // Advance until DivDone is seen; lat is the cycle number (0 = start cycle), capped at 40
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (bus.DivDone === 1'b1) break;
        end
    endtask

    task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        start_op(op, a, b);
        check({tag, "_done_c0"}, {31'b0, bus.DivDone}, 32'd0);
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, bus.DivResult, exp);
        bus.DivStart = 1'b0;
        tick();
        check({tag, "_idle"}, {30'b0, bus.DivBusy, bus.DivDone}, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        int first_at;
        int second_at;
        tests = 0;
        fails = 0;
        rst_n        = 1'b0;
        bus.DivStart = 1'b0;
        bus.DivOp    = 2'b00;
        bus.SrcA     = '0;
        bus.SrcB     = '0;
        repeat (3) tick();
        check("rst_done", {31'b0, bus.DivDone}, 32'd0);
        check("rst_busy", {31'b0, bus.DivBusy}, 32'd0);
        check("rst_res", bus.DivResult, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic signed divide; also check busy in first CALC cycle
        start_op(2'b00, 32'd100, 32'd7);
        tick();
        check("div100_busy_c1", {31'b0, bus.DivBusy}, 32'd1);
        check("div100_done_c1", {31'b0, bus.DivDone}, 32'd0);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (bus.DivDone === 1'b1) break;
        end
        check("div100_lat", lat, 33);
        check("div100_res", bus.DivResult, 32'd14);
        bus.DivStart = 1'b0;
        tick();

        do_div("rem100",   2'b10, 32'd100,        32'd7,          32'd2,          33);
        do_div("div_m7",   2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
        do_div("rem_m7",   2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
        do_div("divu_big", 2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33);
        do_div("div_7_m2", 2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
        do_div("rem_7_m2", 2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33);
        do_div("divu_d0",  2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        do_div("rem_d0",   2'b10, 32'd5,          32'd0,          32'd5,          1);
        do_div("div_ovf",  2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        do_div("rem_ovf",  2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        do_div("divu_nov", 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
        do_div("remu_nov", 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33);

        // abort: drop DivStart during cycle 10
        start_op(2'b00, 32'd100, 32'd7);
        repeat (10) tick();
        bus.DivStart = 1'b0;
        tick();
        check("abort_busy_c11", {31'b0, bus.DivBusy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.DivDone === 1'b1) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 0);
        check("abort_res_kept", bus.DivResult, 32'h8000_0000);

        // synchronous reset at cycle 20 of a divide
        start_op(2'b00, 32'd100, 32'd7);
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_done", {31'b0, bus.DivDone}, 32'd0);
        check("mrst_busy", {31'b0, bus.DivBusy}, 32'd0);
        check("mrst_res", bus.DivResult, 32'd0);
        bus.DivStart = 1'b0;
        rst_n = 1'b1;
        tick();
        do_div("div9_3", 2'b00, 32'd9, 32'd3, 32'd3, 33);

        // back-to-back: DivStart stays high, new operands in the IDLE cycle after DONE
        pulses = 0;
        first_at = -1;
        second_at = -1;
        start_op(2'b01, 32'd1000, 32'd10);
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (bus.DivDone === 1'b1) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = c;
                    check("b2b_res1", bus.DivResult, 32'd100);
                end else if (second_at < 0) begin
                    second_at = c;
                    check("b2b_res2", bus.DivResult, 32'd9);
                    bus.DivStart = 1'b0;
                end
            end
            if (c == first_at + 1 && first_at > 0) begin
                check("b2b_gap_done", {30'b0, bus.DivBusy, bus.DivDone}, 32'd0);
                bus.SrcA = 32'd81;
                bus.SrcB = 32'd9;
            end
        end
        check("b2b_first_at", first_at, 33);
        check("b2b_spacing", second_at - first_at, 34);
        check("b2b_pulses", pulses, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
